// File: rtl/curr_ctu_feeder.sv
// Current-CTU feeder: streams the 64 rows of a 64x64 CTU from current-frame memory
// to the PE array, tagging each row with its CB half and checking the controller's tag.
module curr_ctu_feeder #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned ROW_PIX = 64,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctu_start,
  input  logic [ADDR_W-1:0]          ctu_base,
  input  logic                       in_curr_enable,
  input  logic                       CB_select,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [ROW_PIX*PIX_W-1:0]   mem_rd_data,
  output logic                       curr_valid,
  output logic [ROW_PIX*PIX_W-1:0]   curr_data,
  output logic                       curr_cb12,
  output logic [4:0]                 curr_row,
  output logic                       load_done,
  output logic                       seq_err
);

  localparam int unsigned ROWS  = 64;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned LAST  = MEM_LAT - 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [5:0]                eff_row_c;
  logic [ADDR_W-1:0]         eff_base_c;
  logic                      exp_tag_c;
  logic                      out_last_c;
  logic                      out_take_c;
  logic [MEM_LAT-1:0]        pipe_v;
  logic [MEM_LAT-1:0][5:0]   pipe_row;

  // A ctu_start restarts the row sequence at the new base in the same cycle.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    base_d      = base_q;
    eff_row_c   = ctu_start ? 6'd0 : row_cnt_q[5:0];
    eff_base_c  = ctu_start ? ctu_base : base_q;
    mem_rd_en   = !rst && in_curr_enable &&
                  (ctu_start || (state_q == FETCH && row_cnt_q < CNT_W'(ROWS)));
    mem_rd_addr = eff_base_c + ADDR_W'(eff_row_c);
    exp_tag_c   = ~eff_row_c[5];
    out_take_c  = pipe_v[LAST] && !ctu_start;
    out_last_c  = out_take_c && (pipe_row[LAST] == 6'd63);

    if (ctu_start) begin
      state_d   = FETCH;
      base_d    = ctu_base;
      row_cnt_d = mem_rd_en ? CNT_W'(1) : CNT_W'(0);
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_rd_en) begin
            row_cnt_d = row_cnt_q + CNT_W'(1);
            if (row_cnt_q == CNT_W'(ROWS - 1)) state_d = DRAIN;
          end
        end
        DRAIN: if (out_last_c) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      base_q    <= base_d;
    end
  end

  // Row tags ride alongside the memory read; a restart drops whatever is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v   <= '0;
      pipe_row <= '0;
    end else begin
      pipe_v[0]   <= mem_rd_en;
      pipe_row[0] <= eff_row_c;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1] && !ctu_start;
        pipe_row[i] <= pipe_row[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_valid <= 1'b0;
      curr_data  <= '0;
      curr_cb12  <= 1'b1;
      curr_row   <= '0;
      load_done  <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      curr_valid <= out_take_c;
      load_done  <= out_last_c;
      seq_err    <= (seq_err && !ctu_start) || (mem_rd_en && (CB_select != exp_tag_c));
      if (out_take_c) begin
        curr_data <= mem_rd_data;
        curr_cb12 <= ~pipe_row[LAST][5];
        curr_row  <= pipe_row[LAST][4:0];
      end
    end
  end

endmodule

// File: tb/tb_curr_ctu_feeder.sv
// Bench for curr_ctu_feeder: memory model plus a row-event queue model checked every cycle.
module tb_curr_ctu_feeder;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned ROW_PIX = 64;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DW      = ROW_PIX * PIX_W;
  localparam logic [DW-1:0] GARB  = {16{32'hDEADBEEF}};

  logic              clk = 1'b0;
  logic              rst;
  logic              ctu_start;
  logic [ADDR_W-1:0] ctu_base;
  logic              in_curr_enable;
  logic              CB_select;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic              curr_valid;
  logic [DW-1:0]     curr_data;
  logic              curr_cb12;
  logic [4:0]        curr_row;
  logic              load_done;
  logic              seq_err;

  curr_ctu_feeder #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .ctu_start(ctu_start), .ctu_base(ctu_base),
    .in_curr_enable(in_curr_enable), .CB_select(CB_select),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .curr_valid(curr_valid), .curr_data(curr_data), .curr_cb12(curr_cb12),
    .curr_row(curr_row), .load_done(load_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] pat(logic [ADDR_W-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 64; k++) r[k*8 +: 8] = 8'(a[7:0] + 8'(k)) ^ {a[11:8], 4'h5};
    return r;
  endfunction

  // Memory: answers each read MEM_LAT cycles later, garbage otherwise.
  int cyc = 0;
  logic              hist_en   [0:1023];
  logic [ADDR_W-1:0] hist_addr [0:1023];

  initial for (int i = 0; i < 1024; i++) begin hist_en[i] = 1'b0; hist_addr[i] = '0; end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc >= MEM_LAT && hist_en[(cyc - MEM_LAT) % 1024])
      mem_rd_data = pat(hist_addr[(cyc - MEM_LAT) % 1024]);
    else
      mem_rd_data = GARB;
  end

  // Model: a fetch cursor plus a queue of rows due at the output on a given cycle.
  typedef struct {int due; int row; logic [ADDR_W-1:0] addr;} pend_t;
  pend_t             pend[$];
  int                m_issued = 64;
  logic [ADDR_W-1:0] m_base   = '0;
  logic              m_err    = 1'b0;
  logic [DW-1:0]     m_data   = '0;
  logic              m_cb12   = 1'b1;
  logic [4:0]        m_row    = '0;

  int rd_count, valid_count, done_count, first_issue, first_valid, last_valid;
  logic [ADDR_W-1:0] first_addr, last_addr;

  task automatic clear_stats();
    rd_count = 0; valid_count = 0; done_count = 0;
    first_issue = -1; first_valid = -1; last_valid = -1;
    first_addr = '0; last_addr = '0;
  endtask

  always @(negedge clk) begin
    logic              en_e, v_e, d_e;
    int                row_e;
    logic [ADDR_W-1:0] base_e;
    pend_t             p;
    hist_en[cyc % 1024]   = mem_rd_en;
    hist_addr[cyc % 1024] = mem_rd_addr;
    if (rst) begin
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_rd_addr", mem_rd_addr, 0);
      chk("rst_valid", curr_valid, 0);
      chk("rst_data", curr_data, 0);
      chk("rst_cb12", curr_cb12, 1);
      chk("rst_row", curr_row, 0);
      chk("rst_done", load_done, 0);
      chk("rst_seq_err", seq_err, 0);
      pend.delete();
      m_issued = 64; m_base = '0; m_err = 1'b0;
      m_data = '0; m_cb12 = 1'b1; m_row = '0;
    end else begin
      en_e   = in_curr_enable && (ctu_start || m_issued < 64);
      row_e  = ctu_start ? 0 : m_issued;
      base_e = ctu_start ? ctu_base : m_base;
      chk("rd_en", mem_rd_en, en_e);
      if (en_e) chk("rd_addr", mem_rd_addr, ADDR_W'(base_e + row_e));
      v_e = 1'b0; d_e = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        v_e = 1'b1; d_e = (p.row == 63);
        m_data = pat(p.addr); m_cb12 = (p.row < 32); m_row = 5'(p.row % 32);
      end
      chk("curr_valid", curr_valid, v_e);
      chk("curr_data", curr_data, m_data);
      chk("curr_cb12", curr_cb12, m_cb12);
      chk("curr_row", curr_row, m_row);
      chk("load_done", load_done, d_e);
      chk("seq_err", seq_err, m_err);
      if (ctu_start) begin
        m_base = ctu_base; m_issued = 0; m_err = 1'b0; pend.delete();
      end
      if (en_e) begin
        if (CB_select != (row_e < 32)) m_err = 1'b1;
        pend.push_back('{cyc + MEM_LAT + 1, row_e, ADDR_W'(base_e + row_e)});
        m_issued = row_e + 1;
      end
    end
    if (mem_rd_en) begin
      if (first_issue < 0) begin first_issue = cyc; first_addr = mem_rd_addr; end
      last_addr = mem_rd_addr;
      rd_count++;
    end
    if (curr_valid) begin
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
      valid_count++;
    end
    if (load_done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [ADDR_W-1:0] base, logic en);
    ctu_start = 1'b1; ctu_base = base; in_curr_enable = en; CB_select = 1'b1;
    tick();
    ctu_start = 1'b0;
  endtask

  task automatic issue_rows(int last, bit bad, int pause_at, int pause_len);
    int r = 1;
    int paused = 0;
    while (r <= last) begin
      if (r == pause_at && paused < pause_len) begin
        in_curr_enable = 1'b0; paused++;
      end else begin
        in_curr_enable = 1'b1; CB_select = bad ? 1'b1 : (r < 32); r++;
      end
      tick();
    end
  endtask

  task automatic finish_load();
    in_curr_enable = 1'b1; CB_select = 1'b0;
    tick();
    in_curr_enable = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1; ctu_start = 1'b0; ctu_base = '0; in_curr_enable = 1'b0; CB_select = 1'b0;
    mem_rd_data = GARB;
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;
    chk("lit_reset_cb12", curr_cb12, 1);
    chk("lit_reset_valid", curr_valid, 0);

    // Enable while idle is ignored
    clear_stats();
    in_curr_enable = 1'b1; CB_select = 1'b1;
    repeat (3) tick();
    in_curr_enable = 1'b0;
    chk("lit_idle_reads", rd_count, 0);

    // Plain load at 0x100
    clear_stats();
    do_start(12'h100, 1'b1);
    issue_rows(63, 0, -1, 0);
    finish_load();
    chk("lit_t1_reads", rd_count, 64);
    chk("lit_t1_valids", valid_count, 64);
    chk("lit_t1_done", done_count, 1);
    chk("lit_t1_first_addr", first_addr, 12'h100);
    chk("lit_t1_last_addr", last_addr, 12'h13F);
    chk("lit_t1_latency", first_valid - first_issue, 3);
    chk("lit_t1_span", last_valid - first_valid, 63);
    chk("lit_t1_seq_err", seq_err, 0);

    // Pause for 5 cycles after row 10
    clear_stats();
    do_start(12'h100, 1'b1);
    issue_rows(63, 0, 11, 5);
    finish_load();
    chk("lit_t2_reads", rd_count, 64);
    chk("lit_t2_done", done_count, 1);
    chk("lit_t2_span", last_valid - first_valid, 68);

    // CB_select stuck at 1, then cleared by next start
    clear_stats();
    do_start(12'h040, 1'b1);
    issue_rows(63, 1, -1, 0);
    finish_load();
    chk("lit_t3_seq_err", seq_err, 1);
    do_start(12'h000, 1'b0);
    chk("lit_t3_cleared", seq_err, 0);

    // Address wrap
    clear_stats();
    do_start(12'hFE0, 1'b1);
    issue_rows(63, 0, -1, 0);
    finish_load();
    chk("lit_t4_first_addr", first_addr, 12'hFE0);
    chk("lit_t4_last_addr", last_addr, 12'h01F);
    chk("lit_t4_reads", rd_count, 64);

    // Reset mid-load at row 40, then reload
    do_start(12'h500, 1'b1);
    issue_rows(40, 0, -1, 0);
    rst = 1'b1; in_curr_enable = 1'b1;
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("lit_t5_valids_after_rst", valid_count, 0);
    chk("lit_t5_reads_after_rst", rd_count, 0);
    clear_stats();
    do_start(12'h200, 1'b1);
    issue_rows(63, 0, -1, 0);
    finish_load();
    chk("lit_t5_reload_valids", valid_count, 64);
    chk("lit_t5_reload_first", first_addr, 12'h200);

    // Restart during drain
    do_start(12'h300, 1'b1);
    issue_rows(63, 0, -1, 0);
    clear_stats();
    do_start(12'h400, 1'b1);
    issue_rows(63, 0, -1, 0);
    finish_load();
    chk("lit_t6_valids", valid_count, 65);
    chk("lit_t6_done", done_count, 1);
    chk("lit_t6_first_addr", first_addr, 12'h400);
    chk("lit_t6_reads", rd_count, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
